// File: rtl/fifo_defines_pkg.sv
// Shared definitions for the FIFO / function-generator pair: data widths,
// sequencer state encoding and waveform select codes.
package fifo_defines_pkg;

  localparam int INT_BITS = 8;
  localparam int LUT_ADDR = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CONF = 3'd1,
    CLR  = 3'd2,
    GEN  = 3'd3,
    DONE = 3'd4
  } fgen_state_t;

  localparam logic [1:0] SEL_SIN = 2'd0;
  localparam logic [1:0] SEL_COS = 2'd1;
  localparam logic [1:0] SEL_TRI = 2'd2;
  localparam logic [1:0] SEL_SQU = 2'd3;

endpackage

// File: rtl/fgen_rate_div.sv
// Sample-rate divider: counts 0..div and raises tick at div. While hold is
// high the count parks at div, so a blocked tick stays pending.
module fgen_rate_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             hold,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] count_reg;
  logic             at_div;

  assign at_div = (count_reg == div);
  assign tick   = en && at_div;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      if (at_div) begin
        if (!hold) count_reg <= '0;
      end else begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fgen_seq_ctrl.sv
// Sequencing controller for the LUT function generator feeding the FIFO.
// Optional build macro FGEN_AUTO_RESTART_EN: DONE re-enters CLR unless stopped.
module fgen_seq_ctrl
  import fifo_defines_pkg::*;
#(
  parameter int INT_BITS = 8,
  parameter int BURST_W  = 8,
  parameter int DIV_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic [1:0]          sel_i,
  input  logic [INT_BITS-1:0] amp_i,
  input  logic [BURST_W-1:0]  burst_len_i,
  input  logic [DIV_W-1:0]    rate_div_i,
  input  logic                fifo_afull_i,
  output logic                enh_conf_o,
  output logic                clrh_addr_o,
  output logic                enh_gen_o,
  output logic [1:0]          sel_o,
  output logic [INT_BITS-1:0] amp_o,
  output logic                wr_en_o,
  output logic                busy_o,
  output logic                done_o
);

  fgen_state_t          state_reg, state_next;
  logic [1:0]           sel_reg;
  logic [INT_BITS-1:0]  amp_reg;
  logic [BURST_W-1:0]   burst_reg;
  logic [DIV_W-1:0]     div_reg;
  logic [BURST_W-1:0]   cnt_reg, cnt_next;
  logic                 cfg_valid_reg;
  logic                 wr_en_reg;
  logic                 tick;
  logic                 gen_step;
  logic                 burst_end;

  fgen_rate_div #(.DIV_W(DIV_W)) u_rate_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_reg == CLR),
    .en   (state_reg == GEN),
    .hold (fifo_afull_i),
    .div  (div_reg),
    .tick (tick)
  );

  // A stop coinciding with a tick wins: the step is dropped, not deferred.
  assign gen_step  = (state_reg == GEN) && tick && !fifo_afull_i && !stop_i;
  assign cnt_next  = cnt_reg + 1'b1;
  assign burst_end = gen_step && (burst_reg != '0) && (cnt_next == burst_reg);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (cfg_i)                        state_next = CONF;
        else if (start_i && cfg_valid_reg) state_next = CLR;
      end
      CONF: state_next = IDLE;
      CLR:  state_next = GEN;
      GEN: begin
        if (stop_i)         state_next = IDLE;
        else if (burst_end) state_next = DONE;
      end
      DONE: begin
`ifdef FGEN_AUTO_RESTART_EN
        state_next = stop_i ? IDLE : CLR;
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      sel_reg       <= '0;
      amp_reg       <= '0;
      burst_reg     <= '0;
      div_reg       <= '0;
      cnt_reg       <= '0;
      cfg_valid_reg <= 1'b0;
      wr_en_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      wr_en_reg <= gen_step;
      if (state_reg == IDLE && cfg_i) begin
        sel_reg       <= sel_i;
        amp_reg       <= amp_i;
        burst_reg     <= burst_len_i;
        div_reg       <= rate_div_i;
        cfg_valid_reg <= 1'b1;
      end
      if (state_reg == CLR) cnt_reg <= '0;
      else if (gen_step)    cnt_reg <= cnt_next;
    end
  end

  assign enh_conf_o  = (state_reg == CONF);
  assign clrh_addr_o = (state_reg == CLR);
  assign enh_gen_o   = gen_step;
  assign wr_en_o     = wr_en_reg;
  assign done_o      = (state_reg == DONE);
  assign busy_o      = (state_reg == CONF) || (state_reg == CLR) || (state_reg == GEN);
  assign sel_o       = sel_reg;
  assign amp_o       = amp_reg;

endmodule
